// File: rtl/fpga_cmd_rx_pkg.sv
// Shared command codes, field widths and reset values for the ARM->FPGA command receiver.
package fpga_cmd_rx_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned SHIFT_W = CMD_W + DATA_W;
  localparam int unsigned CONF_W  = 9;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [CMD_W-1:0] CMD_SET_CONFREG    = 4'h1;
  localparam logic [CMD_W-1:0] CMD_SET_DIVISOR    = 4'h2;
  localparam logic [CMD_W-1:0] CMD_SET_USER_BYTE1 = 4'h3;
  localparam logic [CMD_W-1:0] CMD_TRACE_ENABLE   = 4'h4;

  localparam logic [2:0] FPGA_MAJOR_MODE_OFF = 3'b111;

  // Major mode OFF, subcarrier and minor mode zero
  localparam logic [CONF_W-1:0] CONF_RESET_DEFAULT = {FPGA_MAJOR_MODE_OFF, 6'h00};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

  // One received frame: command nibble first on the wire, then 12 data bits
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/fpga_cmd_rx_if.sv
// SPI pins from the ARM plus the decoded configuration outputs.
interface fpga_cmd_rx_if;
  import fpga_cmd_rx_pkg::*;

  logic              spck;
  logic              mosi;
  logic              ncs;
  logic [CONF_W-1:0] conf_word;
  logic              trace_enable;
  logic [BYTE_W-1:0] divisor;
  logic [BYTE_W-1:0] user_byte1;
  logic              conf_update;
  logic              frame_err;

  // ARM side: drives the pins, observes the configuration
  modport master (
    output spck, mosi, ncs,
    input  conf_word, trace_enable, divisor, user_byte1, conf_update, frame_err
  );

  // Receiver side
  modport slave (
    input  spck, mosi, ncs,
    output conf_word, trace_enable, divisor, user_byte1, conf_update, frame_err
  );

endinterface

// File: rtl/fpga_cmd_rx_sync_edge.sv
// Two-flop synchronizer with a delay flop and registered rise/fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic dly_q;

  // Synchronize the pin, then compare against the previous synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1_q  <= d;
      s2_q  <= s1_q;
      dly_q <= s2_q;
      rise  <= s2_q & ~dly_q;
      fall  <= ~s2_q & dly_q;
    end
  end

endmodule

// File: rtl/fpga_cmd_rx.sv
// Oversampling receiver for 16-bit ARM->FPGA command frames; decodes into config registers.
module fpga_cmd_rx
  import fpga_cmd_rx_pkg::*;
#(
  parameter int unsigned        FRAME_BITS = 16,
  parameter logic [CONF_W-1:0]  CONF_RESET = CONF_RESET_DEFAULT
) (
  input  logic          ck_1356meg,
  input  logic          nreset,
  fpga_cmd_rx_if.slave  bus
);

  localparam int unsigned   CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic spck_rise;
  logic spck_fall;
  logic ncs_rise;
  logic ncs_fall;
  logic mosi_s1_q;
  logic mosi_s2_q;

  rx_state_e          state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit_ok;
  logic               commit_err;
  frame_t             frame;

  logic [CONF_W-1:0]  conf_word_q;
  logic               trace_enable_q;
  logic [BYTE_W-1:0]  divisor_q;
  logic [BYTE_W-1:0]  user_byte1_q;
  logic               conf_update_q;
  logic               frame_err_q;
  logic               unused_data;

  sync_edge u_spck_sync (
    .clk   (ck_1356meg),
    .rst_n (nreset),
    .d     (bus.spck),
    .rise  (spck_rise),
    .fall  (spck_fall)
  );

  sync_edge u_ncs_sync (
    .clk   (ck_1356meg),
    .rst_n (nreset),
    .d     (bus.ncs),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // mosi synchronizer; data is stable for several cycles around each spck rise
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  // FSM state, shift register and bit counter
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and frame capture; ncs rise has priority over a same-cycle spck rise
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (spck_rise) begin
          shift_d = {shift_q[SHIFT_W-2:0], mosi_s2_q};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_FULL) begin
          commit_ok = 1'b1;
        end else begin
          commit_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame       = frame_t'(shift_q);
  assign unused_data = &{1'b0, frame.data[DATA_W-1:CONF_W], spck_fall};

  // Command decode into the configuration registers
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      conf_word_q    <= CONF_RESET;
      trace_enable_q <= 1'b0;
      divisor_q      <= '0;
      user_byte1_q   <= '0;
      conf_update_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      conf_update_q <= 1'b0;
      frame_err_q   <= commit_err;
      if (commit_ok) begin
        case (frame.cmd)
          CMD_SET_CONFREG: begin
            conf_word_q   <= frame.data[CONF_W-1:0];
            conf_update_q <= 1'b1;
          end
          CMD_SET_DIVISOR:    divisor_q      <= frame.data[BYTE_W-1:0];
          CMD_SET_USER_BYTE1: user_byte1_q   <= frame.data[BYTE_W-1:0];
          CMD_TRACE_ENABLE:   trace_enable_q <= frame.data[0];
          default: ;
        endcase
      end
    end
  end

  assign bus.conf_word    = conf_word_q;
  assign bus.trace_enable = trace_enable_q;
  assign bus.divisor      = divisor_q;
  assign bus.user_byte1   = user_byte1_q;
  assign bus.conf_update  = conf_update_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_fpga_cmd_rx.sv
// Directed bench for fpga_cmd_rx: drives SPI frames on the pins and checks decoded outputs.
module tb_fpga_cmd_rx;

  logic clk;
  logic nreset;
  int   n_pass;
  int   n_total;
  int   err_cnt;
  int   upd_cnt;

  fpga_cmd_rx_if bus ();

  fpga_cmd_rx dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the one-cycle strobes
  always @(posedge clk) begin
    if (bus.frame_err === 1'b1)   err_cnt <= err_cnt + 1;
    if (bus.conf_update === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  task automatic send_bit(input logic b);
    bus.mosi = b;
    repeat (3) @(negedge clk);
    bus.spck = 1'b1;
    repeat (3) @(negedge clk);
    bus.spck = 1'b0;
  endtask

  // Sends nbits MSB first; with coincide the last spck rise lands together with ncs rise
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit coincide);
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (coincide && i == 0) begin
        bus.mosi = data[i];
        repeat (3) @(negedge clk);
        bus.spck = 1'b1;
        bus.ncs  = 1'b1;
        repeat (3) @(negedge clk);
        bus.spck = 1'b0;
      end else begin
        send_bit(data[i]);
      end
    end
    if (!coincide) begin
      repeat (3) @(negedge clk);
      bus.ncs = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    nreset   = 1'b0;
    bus.spck = 1'b0;
    bus.mosi = 1'b0;
    bus.ncs  = 1'b1;
    err_cnt  = 0;
    upd_cnt  = 0;
    repeat (4) @(negedge clk);
    n_total++; if (bus.conf_word !== 9'h1C0) $display("FAIL reset_conf_word got=%h exp=1c0", bus.conf_word); else n_pass++;
    n_total++; if (bus.trace_enable !== 1'b0) $display("FAIL reset_trace got=%b exp=0", bus.trace_enable); else n_pass++;
    n_total++; if (bus.divisor !== 8'h00) $display("FAIL reset_divisor got=%h exp=00", bus.divisor); else n_pass++;
    n_total++; if (bus.user_byte1 !== 8'h00) $display("FAIL reset_user_byte1 got=%h exp=00", bus.user_byte1); else n_pass++;
    n_total++; if (bus.conf_update !== 1'b0 || bus.frame_err !== 1'b0)
      $display("FAIL reset_pulses got=%b%b exp=00", bus.conf_update, bus.frame_err); else n_pass++;
    nreset = 1'b1;
    settle();
    n_total++; if (err_cnt !== 0) $display("FAIL reset_release_err got=%0d exp=0", err_cnt); else n_pass++;
  endtask

  task automatic test_confreg_latency();
    int u0;
    u0 = upd_cnt;
    send_frame(32'h1042, 16, 1'b0);
    repeat (4) @(negedge clk);
    n_total++; if (bus.conf_word !== 9'h1C0 || bus.conf_update !== 1'b0)
      $display("FAIL latency_early got=%h/%b exp=1c0/0", bus.conf_word, bus.conf_update); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.conf_word !== 9'h042) $display("FAIL confreg_value got=%h exp=042", bus.conf_word); else n_pass++;
    n_total++; if (bus.conf_update !== 1'b1) $display("FAIL conf_update_high got=%b exp=1", bus.conf_update); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.conf_update !== 1'b0) $display("FAIL conf_update_low got=%b exp=0", bus.conf_update); else n_pass++;
    settle();
    n_total++; if (upd_cnt - u0 !== 1) $display("FAIL conf_update_count got=%0d exp=1", upd_cnt - u0); else n_pass++;
  endtask

  task automatic test_trace_divisor();
    int u0;
    int e0;
    u0 = upd_cnt;
    e0 = err_cnt;
    send_frame(32'h4001, 16, 1'b0);
    settle();
    send_frame(32'h20FA, 16, 1'b0);
    settle();
    n_total++; if (bus.trace_enable !== 1'b1) $display("FAIL trace_enable got=%b exp=1", bus.trace_enable); else n_pass++;
    n_total++; if (bus.divisor !== 8'hFA) $display("FAIL divisor got=%h exp=fa", bus.divisor); else n_pass++;
    n_total++; if (bus.conf_word !== 9'h042) $display("FAIL td_conf_word got=%h exp=042", bus.conf_word); else n_pass++;
    n_total++; if (upd_cnt - u0 !== 0) $display("FAIL td_conf_update got=%0d exp=0", upd_cnt - u0); else n_pass++;
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL td_frame_err got=%0d exp=0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_bad_length();
    int e0;
    int u0;
    e0 = err_cnt;
    u0 = upd_cnt;
    send_frame(32'h0000_1111, 15, 1'b0);
    settle();
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL short_frame_err got=%0d exp=1", err_cnt - e0); else n_pass++;
    send_frame(32'h0001_1055, 17, 1'b0);
    settle();
    n_total++; if (err_cnt - e0 !== 2) $display("FAIL long_frame_err got=%0d exp=2", err_cnt - e0); else n_pass++;
    n_total++; if (bus.conf_word !== 9'h042 || upd_cnt - u0 !== 0)
      $display("FAIL bad_len_conf got=%h/%0d exp=042/0", bus.conf_word, upd_cnt - u0); else n_pass++;
    n_total++; if (bus.divisor !== 8'hFA || bus.trace_enable !== 1'b1 || bus.user_byte1 !== 8'h00)
      $display("FAIL bad_len_regs got=%h/%b/%h exp=fa/1/00", bus.divisor, bus.trace_enable, bus.user_byte1); else n_pass++;
  endtask

  task automatic test_unknown_cmd();
    int e0;
    int u0;
    e0 = err_cnt;
    u0 = upd_cnt;
    send_frame(32'hF123, 16, 1'b0);
    settle();
    n_total++; if (err_cnt - e0 !== 0) $display("FAIL unknown_frame_err got=%0d exp=0", err_cnt - e0); else n_pass++;
    n_total++; if (upd_cnt - u0 !== 0) $display("FAIL unknown_update got=%0d exp=0", upd_cnt - u0); else n_pass++;
    n_total++; if (bus.conf_word !== 9'h042 || bus.divisor !== 8'hFA || bus.user_byte1 !== 8'h00 || bus.trace_enable !== 1'b1)
      $display("FAIL unknown_regs got=%h/%h/%h/%b exp=042/fa/00/1", bus.conf_word, bus.divisor, bus.user_byte1, bus.trace_enable);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] f;
    int e0;
    int u0;
    f = 16'h1055;
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 15; i >= 8; i--) send_bit(f[i]);
    nreset = 1'b0;
    @(negedge clk);
    n_total++; if (bus.conf_word !== 9'h1C0 || bus.trace_enable !== 1'b0 || bus.divisor !== 8'h00)
      $display("FAIL midreset_values got=%h/%b/%h exp=1c0/0/00", bus.conf_word, bus.trace_enable, bus.divisor); else n_pass++;
    @(negedge clk);
    nreset = 1'b1;
    e0 = err_cnt;
    u0 = upd_cnt;
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    repeat (3) @(negedge clk);
    bus.ncs = 1'b1;
    settle();
    n_total++; if (err_cnt - e0 !== 0 || upd_cnt - u0 !== 0)
      $display("FAIL midreset_tail got=%0d/%0d exp=0/0", err_cnt - e0, upd_cnt - u0); else n_pass++;
    send_frame(32'h3077, 16, 1'b0);
    settle();
    n_total++; if (bus.user_byte1 !== 8'h77) $display("FAIL user_byte1 got=%h exp=77", bus.user_byte1); else n_pass++;
    n_total++; if (bus.conf_word !== 9'h1C0) $display("FAIL midreset_conf_word got=%h exp=1c0", bus.conf_word); else n_pass++;
  endtask

  task automatic test_coincident_edge();
    int e0;
    int u0;
    e0 = err_cnt;
    u0 = upd_cnt;
    send_frame(32'h1042, 16, 1'b1);
    settle();
    n_total++; if (err_cnt - e0 !== 1) $display("FAIL coincide_frame_err got=%0d exp=1", err_cnt - e0); else n_pass++;
    n_total++; if (upd_cnt - u0 !== 0) $display("FAIL coincide_update got=%0d exp=0", upd_cnt - u0); else n_pass++;
    n_total++; if (bus.conf_word !== 9'h1C0) $display("FAIL coincide_conf_word got=%h exp=1c0", bus.conf_word); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_confreg_latency();
    test_trace_divisor();
    test_bad_length();
    test_unknown_cmd();
    test_reset_mid_frame();
    test_coincident_edge();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
